bus_watchdog: RTL and testbench

BUS_WATCHDOG -- requirements
Module: bus_watchdog

---
 rtl/bus_watchdog_if.sv | 35 +++
 rtl/bus_watchdog.sv | 147 ++++++++++++++
 tb/tb_bus_watchdog.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_watchdog_if.sv
// rtl/bus_watchdog_if.sv - CPU, interconnect and CSR signal bundle for bus_watchdog
interface bus_watchdog_if;
  logic        cpuRead;
  logic        cpuWrite;
  logic [31:0] cpuAddress;
  logic        cpuWaitRequest;
  logic        cpuReadValid;
  logic [31:0] cpuDataIn;
  logic        slvRead;
  logic        slvWrite;
  logic        slvWaitRequest;
  logic        slvReadValid;
  logic [31:0] slvDataIn;
  logic        csrRead;
  logic        csrWrite;
  logic [1:0]  csrAddress;
  logic [31:0] csrDataIn;
  logic        csrReadValid;
  logic [31:0] csrDataOut;
  logic        irq;

  modport slave (
    input  cpuRead, cpuWrite, cpuAddress, slvWaitRequest, slvReadValid, slvDataIn,
           csrRead, csrWrite, csrAddress, csrDataIn,
    output cpuWaitRequest, cpuReadValid, cpuDataIn, slvRead, slvWrite,
           csrReadValid, csrDataOut, irq
  );

  modport master (
    output cpuRead, cpuWrite, cpuAddress, slvWaitRequest, slvReadValid, slvDataIn,
           csrRead, csrWrite, csrAddress, csrDataIn,
    input  cpuWaitRequest, cpuReadValid, cpuDataIn, slvRead, slvWrite,
           csrReadValid, csrDataOut, irq
  );
endinterface

// File: rtl/bus_watchdog.sv
// rtl/bus_watchdog.sv - bus timeout watchdog: drops stuck requests, injects fault data on lost reads
module bus_watchdog #(
  parameter int unsigned TIMEOUT_DEFAULT = 1024,
  parameter logic [31:0] FAULT_DATA      = 32'hDEADBEEF
) (
  input logic           clk,
  input logic           reset,
  bus_watchdog_if.slave bus
);

  typedef enum logic [2:0] {IDLE, STALL, PENDING, DROP, INJECT} stateT;

  localparam logic [15:0] LIMIT_RESET = 16'(TIMEOUT_DEFAULT);

  stateT       state;
  logic [15:0] counter;
  logic [15:0] counterNext;
  logic [15:0] limit;
  logic        isRead;
  logic [3:0]  status;
  logic [3:0]  statusNext;
  logic [31:0] faultAddr;
  logic [31:0] csrMux;
  logic        timeout;
  logic        faultEvent;
  logic        lateResp;
  logic        unusedCsrBits;

  // Timeout fires on the cycle that would complete `limit` cycles in STALL/PENDING.
  assign counterNext = counter + 16'd1;
  assign timeout     = counterNext >= limit;
  assign faultEvent  = timeout && ((state == STALL && bus.slvWaitRequest) ||
                                   (state == PENDING && !bus.slvReadValid));
  assign lateResp    = bus.slvReadValid && (state != PENDING);
  assign unusedCsrBits = ^bus.csrDataIn[31:16];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      counter <= 16'd0;
      isRead  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpuRead || bus.cpuWrite) begin
            isRead  <= bus.cpuRead;
            counter <= 16'd0;
            if (bus.slvWaitRequest) state <= STALL;
            else if (bus.cpuRead)   state <= PENDING;
          end
        end
        STALL: begin
          counter <= counterNext;
          if (!bus.slvWaitRequest) begin
            if (isRead) begin
              state   <= PENDING;
              counter <= 16'd0;
            end else begin
              state <= IDLE;
            end
          end else if (timeout) begin
            state <= DROP;
          end
        end
        PENDING: begin
          counter <= counterNext;
          if (bus.slvReadValid) state <= IDLE;
          else if (timeout)     state <= INJECT;
        end
        DROP:    state <= isRead ? INJECT : IDLE;
        INJECT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Clear first, then apply new events so a same-cycle fault survives a W1C.
  always_comb begin
    statusNext = status;
    if (bus.csrWrite && bus.csrAddress == 2'd0)
      statusNext = status & ~bus.csrDataIn[3:0];
    if (faultEvent) begin
      statusNext[0] = 1'b1;
      statusNext[1] = status[0];
      statusNext[2] = isRead;
    end
    if (lateResp)
      statusNext[3] = 1'b1;
  end

  always_comb begin
    csrMux = 32'd0;
    case (bus.csrAddress)
      2'd0:    csrMux = {28'd0, status};
      2'd1:    csrMux = faultAddr;
      2'd2:    csrMux = {16'd0, limit};
      default: csrMux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status           <= 4'd0;
      faultAddr        <= 32'd0;
      limit            <= LIMIT_RESET;
      bus.csrReadValid <= 1'b0;
      bus.csrDataOut   <= 32'd0;
    end else begin
      status           <= statusNext;
      bus.csrReadValid <= bus.csrRead;
      bus.csrDataOut   <= bus.csrRead ? csrMux : 32'd0;
      if (faultEvent)
        faultAddr <= bus.cpuAddress;
      if (bus.csrWrite && bus.csrAddress == 2'd2)
        limit <= (bus.csrDataIn[15:0] == 16'd0) ? 16'd1 : bus.csrDataIn[15:0];
    end
  end

  always_comb begin
    bus.slvRead        = 1'b0;
    bus.slvWrite       = 1'b0;
    bus.cpuWaitRequest = 1'b0;
    bus.cpuReadValid   = 1'b0;
    bus.cpuDataIn      = 32'd0;
    case (state)
      IDLE, STALL: begin
        bus.slvRead        = bus.cpuRead;
        bus.slvWrite       = bus.cpuWrite;
        bus.cpuWaitRequest = bus.slvWaitRequest;
      end
      PENDING: begin
        bus.cpuWaitRequest = 1'b1;
        bus.cpuReadValid   = bus.slvReadValid;
        bus.cpuDataIn      = bus.slvReadValid ? bus.slvDataIn : 32'd0;
      end
      INJECT: begin
        bus.cpuWaitRequest = 1'b1;
        bus.cpuReadValid   = 1'b1;
        bus.cpuDataIn      = FAULT_DATA;
      end
      default: ;
    endcase
  end

  assign bus.irq = status[0];

endmodule

// File: tb/tb_bus_watchdog.sv
// tb/tb_bus_watchdog.sv - scoreboard bench for bus_watchdog
module tb_bus_watchdog;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] cpuQ[$];
  logic [31:0] csrQ[$];

  bus_watchdog_if bus ();

  bus_watchdog #(.TIMEOUT_DEFAULT(1024), .FAULT_DATA(32'hDEADBEEF)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents read data.
  always @(negedge clk) begin
    if (bus.cpuReadValid === 1'b1) begin
      if (cpuQ.size() == 0) check("cpuReadValid unexpected", {31'd0, bus.cpuReadValid}, 32'd0);
      else                  check("cpuDataIn", bus.cpuDataIn, cpuQ.pop_front());
    end
    if (bus.csrReadValid === 1'b1) begin
      if (csrQ.size() == 0) check("csrReadValid unexpected", {31'd0, bus.csrReadValid}, 32'd0);
      else                  check("csrDataOut", bus.csrDataOut, csrQ.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csrWr(input logic [1:0] a, input logic [31:0] d);
    bus.csrWrite = 1'b1; bus.csrAddress = a; bus.csrDataIn = d;
    tick();
    bus.csrWrite = 1'b0;
  endtask

  task automatic csrRd(input logic [1:0] a, input logic [31:0] exp);
    csrQ.push_back(exp);
    bus.csrRead = 1'b1; bus.csrAddress = a;
    tick();
    bus.csrRead = 1'b0;
    tick();
  endtask

  // Read accepted immediately, slave never answers; ends back in IDLE.
  task automatic readTimeout(input logic [31:0] addr, input int lim);
    cpuQ.push_back(32'hDEADBEEF);
    bus.cpuRead = 1'b1; bus.cpuAddress = addr; bus.slvWaitRequest = 1'b0;
    tick();
    bus.cpuRead = 1'b0;
    repeat (lim) tick();
    tick();
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0;
    bus.cpuRead = 0; bus.cpuWrite = 0; bus.cpuAddress = 0;
    bus.slvWaitRequest = 0; bus.slvReadValid = 0; bus.slvDataIn = 0;
    bus.csrRead = 0; bus.csrWrite = 0; bus.csrAddress = 0; bus.csrDataIn = 0;
    repeat (3) tick();
    check("reset csrReadValid", {31'd0, bus.csrReadValid}, 32'd0);
    check("reset csrDataOut", bus.csrDataOut, 32'd0);
    check("reset irq", {31'd0, bus.irq}, 32'd0);
    check("reset cpuReadValid", {31'd0, bus.cpuReadValid}, 32'd0);
    bus.cpuRead = 1'b1; bus.slvWaitRequest = 1'b1; #1;
    check("reset passthru slvRead", {31'd0, bus.slvRead}, 32'd1);
    check("reset passthru wait", {31'd0, bus.cpuWaitRequest}, 32'd1);
    bus.cpuRead = 1'b0; bus.slvWaitRequest = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    csrRd(2'd0, 32'd0);
    csrRd(2'd1, 32'd0);
    csrRd(2'd2, 32'd1024);
    csrRd(2'd3, 32'd0);

    // Responsive slave: data 3 cycles after accept.
    cpuQ.push_back(32'hCAFE0001);
    bus.cpuRead = 1'b1; bus.cpuAddress = 32'h0000_0100;
    tick();
    bus.cpuRead = 1'b0;
    tick(); tick();
    bus.slvReadValid = 1'b1; bus.slvDataIn = 32'hCAFE0001;
    tick();
    bus.slvReadValid = 1'b0;
    csrRd(2'd0, 32'd0);

    // Read timeout with limit 8: PENDING for 8 cycles, then INJECT.
    csrWr(2'd2, 32'd8);
    csrRd(2'd2, 32'd8);
    cpuQ.push_back(32'hDEADBEEF);
    bus.cpuRead = 1'b1; bus.cpuAddress = 32'h2000_0040;
    tick();
    bus.cpuRead = 1'b0;
    repeat (7) tick();
    check("inject not early", {31'd0, bus.cpuReadValid}, 32'd0);
    tick();
    check("inject valid", {31'd0, bus.cpuReadValid}, 32'd1);
    check("inject wait", {31'd0, bus.cpuWaitRequest}, 32'd1);
    tick();
    csrRd(2'd0, 32'h5);
    csrRd(2'd1, 32'h2000_0040);
    check("irq after fault", {31'd0, bus.irq}, 32'd1);

    // Late response in IDLE is swallowed and flagged.
    bus.slvReadValid = 1'b1; bus.slvDataIn = 32'h5555_AAAA; #1;
    check("late suppressed", {31'd0, bus.cpuReadValid}, 32'd0);
    tick();
    bus.slvReadValid = 1'b0;
    csrRd(2'd0, 32'hD);
    csrWr(2'd0, 32'hF);
    csrRd(2'd0, 32'h0);
    check("irq cleared", {31'd0, bus.irq}, 32'd0);

    // Write stuck in STALL with limit 4: DROP after 4 stall cycles.
    csrWr(2'd2, 32'd4);
    bus.cpuWrite = 1'b1; bus.slvWaitRequest = 1'b1; bus.cpuAddress = 32'h3000_0000; #1;
    check("stall slvWrite", {31'd0, bus.slvWrite}, 32'd1);
    tick();
    repeat (3) tick();
    check("last stall wait", {31'd0, bus.cpuWaitRequest}, 32'd1);
    tick();
    check("drop slvWrite", {31'd0, bus.slvWrite}, 32'd0);
    check("drop wait", {31'd0, bus.cpuWaitRequest}, 32'd0);
    bus.cpuWrite = 1'b0; bus.slvWaitRequest = 1'b0;
    tick();
    csrRd(2'd0, 32'h1);
    csrRd(2'd1, 32'h3000_0000);
    csrWr(2'd0, 32'hF);

    // readValid on the timeout cycle wins.
    cpuQ.push_back(32'h1234_5678);
    bus.cpuRead = 1'b1; bus.cpuAddress = 32'h4000_0000;
    tick();
    bus.cpuRead = 1'b0;
    repeat (3) tick();
    bus.slvReadValid = 1'b1; bus.slvDataIn = 32'h1234_5678;
    tick();
    bus.slvReadValid = 1'b0;
    csrRd(2'd0, 32'h0);

    // Two faults without clearing; second coincides with a W1C.
    csrWr(2'd2, 32'd2);
    readTimeout(32'h5000_0000, 2);
    csrRd(2'd0, 32'h5);
    cpuQ.push_back(32'hDEADBEEF);
    bus.cpuRead = 1'b1; bus.cpuAddress = 32'h5000_0004;
    tick();
    bus.cpuRead = 1'b0;
    tick();
    bus.csrWrite = 1'b1; bus.csrAddress = 2'd0; bus.csrDataIn = 32'hF;
    tick();
    bus.csrWrite = 1'b0;
    tick();
    csrRd(2'd0, 32'h7);
    csrRd(2'd1, 32'h5000_0004);
    csrWr(2'd0, 32'hF);
    csrWr(2'd2, 32'd0);
    csrRd(2'd2, 32'd1);

    // Reset during PENDING aborts with no inject.
    csrWr(2'd2, 32'd8);
    bus.cpuRead = 1'b1; bus.cpuAddress = 32'h6000_0000;
    tick();
    bus.cpuRead = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("reset abort cpuReadValid", {31'd0, bus.cpuReadValid}, 32'd0);
    tick(); tick();
    reset = 1'b1;
    repeat (12) tick();
    csrRd(2'd2, 32'd1024);
    csrRd(2'd0, 32'd0);
    bus.cpuRead = 1'b1; bus.slvWaitRequest = 1'b1; #1;
    check("post-reset slvRead", {31'd0, bus.slvRead}, 32'd1);
    check("post-reset wait", {31'd0, bus.cpuWaitRequest}, 32'd1);
    bus.cpuRead = 1'b0; bus.slvWaitRequest = 1'b0;
    tick();

    for (int i = 0; i < 20 && (cpuQ.size() != 0 || csrQ.size() != 0); i++) tick();
    check("cpuQ drained", cpuQ.size(), 32'd0);
    check("csrQ drained", csrQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
